// File: rtl/ex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_pkg : shared types and defaults for the EX pipeline stage               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ex_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [XLEN_DEF-1:0] store_data;
    logic [REGW_DEF-1:0] dest_reg;
    logic                wmem;
    logic                rmem;
    logic                wreg;
  } ex_mem_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mul_iter : radix-2 shift-add multiplier, low XLEN bits, XLEN iterations |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_next;

  // product is the accumulator after the final iteration, so the consumer
  // can capture it on the same edge that retires the last step
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy & (cnt == CW'(XLEN - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_ex_stage : ID/EX consumer, ALU execute, registered EX/MEM output  |
// | Optional iterative multiplier enabled by macro EX_MUL_EN.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module pipeline_ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] R1i,
  input  logic [XLEN-1:0] R2i,
  input  logic [XLEN-1:0] R3i,
  input  logic [REGW-1:0] destRegi,
  input  logic [2:0]      ALUinsi,
  input  logic            wmemi,
  input  logic            rmemi,
  input  logic            wregi,
  input  logic            immi,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_res_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [REGW-1:0] destRego,
  output logic            wmemo,
  output logic            rmemo,
  output logic            wrego,
  output logic            fwd_valid_o,
  output logic [REGW-1:0] fwd_reg_o,
  output logic [XLEN-1:0] fwd_val_o
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] dest_reg;
    logic            wmem;
    logic            rmem;
    logic            wreg;
  } bundle_t;

  bundle_t         out_q;
  bundle_t         issue_b;
  logic            out_valid;
  logic            accept;
  alu_op_e         op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;

  assign op   = alu_op_e'(ALUinsi);
  assign op_a = R1i;
  assign op_b = immi ? R3i : R2i;

  // MUL yields zero here; the iterative unit supplies the real product
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign issue_b = '{
    result:     alu_res,
    store_data: R2i,
    dest_reg:   destRegi,
    wmem:       wmemi,
    rmem:       rmemi,
    wreg:       wregi
  };

`ifdef EX_MUL_EN
  ex_state_e       state;
  bundle_t         pend_q;
  logic            is_mul;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  assign is_mul    = (op == ALU_MUL);
  assign ready_o   = (state == ST_IDLE) & (~out_valid | ready_i) & rst;
  assign accept    = valid_i & ready_o;
  assign mul_start = accept & is_mul & ~flush_i & ~mul_busy;

  ex_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush_i),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign ready_o = (~out_valid | ready_i) & rst;
  assign accept  = valid_i & ready_o;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
`ifdef EX_MUL_EN
      state     <= ST_IDLE;
      pend_q    <= '0;
`endif
    end else if (flush_i) begin
      out_valid <= 1'b0;
`ifdef EX_MUL_EN
      state     <= ST_IDLE;
`endif
    end
`ifdef EX_MUL_EN
    else if (state == ST_MUL) begin
      // output slot was emptied at issue, so completion never waits
      if (mul_done) begin
        out_q        <= pend_q;
        out_q.result <= mul_prod;
        out_valid    <= 1'b1;
        state        <= ST_IDLE;
      end
    end
`endif
    else if (accept) begin
`ifdef EX_MUL_EN
      if (is_mul) begin
        pend_q    <= issue_b;
        out_valid <= 1'b0;
        state     <= ST_MUL;
      end else
`endif
      begin
        out_q     <= issue_b;
        out_valid <= 1'b1;
      end
    end else if (out_valid && ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign valid_o      = out_valid;
  assign alu_res_o    = out_q.result;
  assign store_data_o = out_q.store_data;
  assign destRego     = out_q.dest_reg;
  assign wmemo        = out_q.wmem;
  assign rmemo        = out_q.rmem;
  assign wrego        = out_q.wreg;

  // loads are not forwardable: their value arrives from memory later
  assign fwd_valid_o  = out_valid & out_q.wreg & ~out_q.rmem;
  assign fwd_reg_o    = out_q.dest_reg;
  assign fwd_val_o    = out_q.result;

endmodule
`default_nettype wire
